// File: rtl/mcu_request_scheduler.sv
// ============================================================================
// mcu_request_scheduler
// Grants the Y, Cb and Cr encoders their per-MCU request windows in turn,
// each MCU followed by an idle guard gap. Tracks the per-component MCU index.
// Optional statistics counters are enabled by defining MCU_SCHED_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mcu_request_scheduler #(
  parameter int unsigned REQ_Y = 29,
  parameter int unsigned REQ_C = 7,
  parameter int unsigned GAP   = 8,
  parameter int unsigned MCU_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               row_start,
  input  logic               frame_start,
  input  logic [MCU_W-1:0]   h_mcu,
  output logic [2:0]         ereq,
  output logic [3*MCU_W-1:0] e_x_mcu,
  output logic               busy,
  output logic               row_done,
  output logic               overrun,
  output logic               frame_err
`ifdef MCU_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_mcus,
  output logic [15:0]        stat_rows
`endif
);

  localparam int unsigned c_max_len = (REQ_Y > REQ_C) ? ((REQ_Y > GAP) ? REQ_Y : GAP)
                                                      : ((REQ_C > GAP) ? REQ_C : GAP);
  localparam int unsigned c_ph_w    = $clog2(c_max_len + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_Y  = 3'd1,
    S_REQ_CB = 3'd2,
    S_REQ_CR = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_ph_w-1:0]  r_phase;
  logic [MCU_W-1:0]   r_h_lat;
  logic [MCU_W-1:0]   r_x_y;
  logic [MCU_W-1:0]   r_x_cb;
  logic [MCU_W-1:0]   r_x_cr;
  logic               r_row_done;
  logic               r_overrun;
  logic               r_frame_err;
  logic [2:0]         w_ereq_dec;
  logic               w_win_end;
  logic               w_row_fin;
  logic               w_busy;
  logic               w_abort;
  logic               w_accept;
  logic               w_row_done_d;

  assign w_busy       = (r_state != S_IDLE);
  assign w_abort      = w_busy && frame_start;
  // frame_start wins over a simultaneous row_start even when idle
  assign w_accept     = !w_busy && row_start && !frame_start;
  assign w_row_done_d = (w_accept && (h_mcu == '0)) || (w_row_fin && !w_abort);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ereq_dec = 3'b000;
    w_win_end  = 1'b0;
    w_row_fin  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (h_mcu != '0)) begin
          w_next = S_REQ_Y;
        end
      end
      S_REQ_Y: begin
        w_ereq_dec = 3'b001;
        if (r_phase == c_ph_w'(REQ_Y - 1)) begin
          w_win_end = 1'b1;
          w_next    = S_REQ_CB;
        end
      end
      S_REQ_CB: begin
        w_ereq_dec = 3'b010;
        if (r_phase == c_ph_w'(REQ_C - 1)) begin
          w_win_end = 1'b1;
          w_next    = S_REQ_CR;
        end
      end
      S_REQ_CR: begin
        w_ereq_dec = 3'b100;
        if (r_phase == c_ph_w'(REQ_C - 1)) begin
          w_win_end = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_GAP: begin
        if (r_phase == c_ph_w'(GAP - 1)) begin
          if (r_x_cr == r_h_lat) begin
            w_row_fin = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_next    = S_REQ_Y;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) begin
      r_phase <= '0;
    end else if (w_busy) begin
      r_phase <= r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_lat     <= '0;
      r_x_y       <= '0;
      r_x_cb      <= '0;
      r_x_cr      <= '0;
      r_row_done  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_row_done <= w_row_done_d;
      if (w_busy && row_start) begin
        r_overrun <= 1'b1;
      end
      if (w_abort) begin
        r_frame_err <= 1'b1;
        r_x_y       <= '0;
        r_x_cb      <= '0;
        r_x_cr      <= '0;
      end else if (w_accept && (h_mcu != '0)) begin
        r_h_lat <= h_mcu;
        r_x_y   <= '0;
        r_x_cb  <= '0;
        r_x_cr  <= '0;
      end else if (w_win_end) begin
        case (r_state)
          S_REQ_Y:  r_x_y  <= r_x_y + 1'b1;
          S_REQ_CB: r_x_cb <= r_x_cb + 1'b1;
          S_REQ_CR: r_x_cr <= r_x_cr + 1'b1;
          default:  ;
        endcase
      end
    end
  end

`ifdef MCU_SCHED_STATS_EN
  logic [31:0] r_stat_mcus;
  logic [15:0] r_stat_rows;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_mcus <= '0;
      r_stat_rows <= '0;
    end else begin
      if ((r_state == S_REQ_CR) && w_win_end && !w_abort && (r_stat_mcus != '1)) begin
        r_stat_mcus <= r_stat_mcus + 1'b1;
      end
      if (w_row_done_d) begin
        r_stat_rows <= r_stat_rows + 1'b1;
      end
    end
  end

  assign stat_mcus = r_stat_mcus;
  assign stat_rows = r_stat_rows;
`endif

  // a frame abort silences the packer in the very cycle it is seen
  assign ereq      = w_ereq_dec & {3{~w_abort}};
  assign e_x_mcu   = {r_x_cr, r_x_cb, r_x_y};
  assign busy      = w_busy;
  assign row_done  = r_row_done;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(ereq)) else $error("ereq not one-hot-or-zero: %b", ereq);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcu_request_scheduler.sv
// ============================================================================
// tb_mcu_request_scheduler
// Scoreboard bench: arithmetic reference model of the MCU schedule.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mcu_request_scheduler;

  localparam int REQ_Y   = 29;
  localparam int REQ_C   = 7;
  localparam int GAP     = 8;
  localparam int MCU_W   = 8;
  localparam int MCU_CYC = REQ_Y + 2 * REQ_C + GAP;

  logic              clk;
  logic              rst;
  logic              row_start;
  logic              frame_start;
  logic [MCU_W-1:0]  h_mcu;
  logic [2:0]        ereq;
  logic [3*MCU_W-1:0] e_x_mcu;
  logic              busy;
  logic              row_done;
  logic              overrun;
  logic              frame_err;
`ifdef MCU_SCHED_STATS_EN
  logic [31:0]       stat_mcus;
  logic [15:0]       stat_rows;
`endif

  mcu_request_scheduler #(
    .REQ_Y(REQ_Y), .REQ_C(REQ_C), .GAP(GAP), .MCU_W(MCU_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_start  (row_start),
    .frame_start(frame_start),
    .h_mcu      (h_mcu),
    .ereq       (ereq),
    .e_x_mcu    (e_x_mcu),
    .busy       (busy),
    .row_done   (row_done),
    .overrun    (overrun),
    .frame_err  (frame_err)
`ifdef MCU_SCHED_STATS_EN
    ,
    .stat_mcus  (stat_mcus),
    .stat_rows  (stat_rows)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] ex;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          started = 0;

  // reference model state
  bit          m_active = 0;
  int          m_t0     = 0;
  int          m_h      = 0;
  logic [23:0] m_fixed  = '0;
  bit          m_ovr    = 0;
  bit          m_ferr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_busy(input int c);
    return m_active && (c >= m_t0 + 1) && (c < m_t0 + 1 + m_h * MCU_CYC);
  endfunction

  function automatic logic [2:0] exp_ereq(input int c);
    int m;
    if (!m_busy(c)) return 3'b000;
    m = (c - m_t0 - 1) % MCU_CYC;
    if (m < REQ_Y) return 3'b001;
    if (m < REQ_Y + REQ_C) return 3'b010;
    if (m < REQ_Y + 2 * REQ_C) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [23:0] exp_ex(input int c);
    int off, r, m, y, cb, cr;
    if (!m_active || c < m_t0 + 1) return m_fixed;
    off = c - m_t0 - 1;
    if (off >= m_h * MCU_CYC) begin
      y = m_h; cb = m_h; cr = m_h;
    end else begin
      r  = off / MCU_CYC;
      m  = off % MCU_CYC;
      y  = r + ((m >= REQ_Y) ? 1 : 0);
      cb = r + ((m >= REQ_Y + REQ_C) ? 1 : 0);
      cr = r + ((m >= REQ_Y + 2 * REQ_C) ? 1 : 0);
    end
    return {cr[7:0], cb[7:0], y[7:0]};
  endfunction

  // Applied at the clock edge that samples the cycle-c inputs.
  task automatic model_update(input bit rs, input bit fs, input bit r, input int hv, input int c);
    bit   b;
    exp_t e;
    if (r) begin
      m_active = 0; m_fixed = '0; m_ovr = 0; m_ferr = 0;
      q.delete();
    end else begin
      b = m_busy(c);
      if (b && rs) m_ovr = 1;
      if (b && fs) begin
        m_ferr   = 1;
        m_active = 0;
        m_fixed  = '0;
        if (q.size() > 0) void'(q.pop_back());
      end else if (!b && rs && !fs) begin
        if (hv == 0) begin
          e.cyc = c + 1;
          e.ex  = exp_ex(c);
          q.push_back(e);
        end else begin
          m_active = 1; m_t0 = c; m_h = hv;
          e.cyc = c + 1 + hv * MCU_CYC;
          e.ex  = {hv[7:0], hv[7:0], hv[7:0]};
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic step(input bit rs, input bit fs, input bit r, input int hv);
    rst = r; row_start = rs; frame_start = fs; h_mcu = hv[MCU_W-1:0];
    @(posedge clk);
    model_update(rs, fs, r, hv, cyc);
    cyc++;
    #1;
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // monitor: per-cycle outputs against the model, row_done against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      chk("ereq", {29'd0, ereq}, {29'd0, (frame_start && m_busy(cyc)) ? 3'b000 : exp_ereq(cyc)});
      chk("e_x_mcu", {8'd0, e_x_mcu}, {8'd0, exp_ex(cyc)});
      chk("busy", {31'd0, busy}, {31'd0, m_busy(cyc)});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      if (row_done) begin
        if (q.size() == 0) begin
          chk("row_done_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("row_done_cycle", cyc, e.cyc);
          chk("row_done_ex", {8'd0, e_x_mcu}, {8'd0, e.ex});
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk("row_done_missing", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; row_start = 1'b0; frame_start = 1'b0; h_mcu = '0;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    idle(3);

    // single MCU row
    step(1, 0, 0, 1);
    idle(60);
    // zero-width row
    step(1, 0, 0, 0);
    idle(5);
    // overrun: second row_start 10 cycles into a 2-MCU row
    step(1, 0, 0, 2);
    idle(9);
    step(1, 0, 0, 5);
    idle(100);
    // frame abort during Cb window of the third MCU
    step(1, 0, 0, 4);
    idle(2 * MCU_CYC + REQ_Y + 2);
    step(0, 1, 0, 0);
    idle(5);
    // reset mid-row, then a fresh single-MCU row
    step(1, 0, 0, 3);
    idle(10);
    step(0, 0, 1, 0);
    idle(2);
    step(1, 0, 0, 1);
    idle(60);
    // simultaneous frame_start and row_start while idle
    step(1, 1, 0, 3);
    idle(5);
    // full-width row
    step(1, 0, 0, 80);
    idle(80 * MCU_CYC + 5);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      int len;
      step(1, 0, 0, int'($urandom_range(0, 4)));
      len = int'($urandom_range(0, 250));
      for (int k = 0; k < len; k++) begin
        step(($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 499) == 0), int'($urandom_range(0, 4)));
      end
    end

    for (int i = 0; i < 6000 && q.size() > 0; i++) idle(1);
    chk("scoreboard_drained", q.size(), 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
